// File: rtl/my_pe_ctrl.sv
// my_pe_ctrl: sequencer for one processing element.
// On start it copies an N-word weight vector from global BRAM into the PE's
// local RAM. It then clears the PE accumulator and streams the N-word input
// vector through the PE MAC, keeping exactly one operand in flight. It returns
// the dot product (or 0 plus a sticky err on a MAC timeout) with a one-cycle
// done pulse.
module my_pe_ctrl #(
  parameter int SIZE       = 32,
  parameter int L_RAM_SIZE = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [SIZE-1:0]       result,
  output logic [L_RAM_SIZE:0]   gaddr,
  input  logic [SIZE-1:0]       gdata,
  output logic                  pe_clr,
  output logic [L_RAM_SIZE-1:0] pe_addr,
  output logic                  pe_we,
  output logic [SIZE-1:0]       pe_din,
  output logic [SIZE-1:0]       pe_ain,
  output logic                  pe_valid,
  input  logic                  pe_dvalid,
  input  logic [SIZE-1:0]       pe_dout
);

  localparam int N      = 2 ** L_RAM_SIZE;
  localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [L_RAM_SIZE:0]   IDX_LAST  = (L_RAM_SIZE+1)'(N - 1);
  localparam logic [L_RAM_SIZE:0]   IDX_ONE   = (L_RAM_SIZE+1)'(1);
  localparam logic [L_RAM_SIZE:0]   IN_BASE   = (L_RAM_SIZE+1)'(N);
  localparam logic [L_RAM_SIZE-1:0] ADDR_ONE  = L_RAM_SIZE'(1);
  localparam logic [WCNT_W-1:0]     WCNT_LAST = WCNT_W'(TIMEOUT - 1);
  localparam logic [WCNT_W-1:0]     WCNT_ONE  = WCNT_W'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_LDRAIN = 3'd2;
  localparam logic [2:0] S_RD     = 3'd3;
  localparam logic [2:0] S_ISSUE  = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]            state_q,  state_d;
  logic [L_RAM_SIZE:0]   idx_q,    idx_d;
  logic [WCNT_W-1:0]     wcnt_q,   wcnt_d;
  logic                  err_q,    err_d;
  logic [SIZE-1:0]       result_q, result_d;
  logic                  we_q,     we_d;
  logic [L_RAM_SIZE-1:0] addr_q,   addr_d;
  logic [SIZE-1:0]       ain_q,    ain_d;

  // Next-state and datapath register update rules for the sequencer.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wcnt_d   = wcnt_q;
    err_d    = err_q;
    result_d = result_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    ain_d    = ain_q;
    case (state_q)
      S_IDLE: begin
        // pe_dvalid is deliberately not looked at here.
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        // The word read at idx arrives next cycle, so its write address
        // is registered alongside the write enable.
        we_d   = 1'b1;
        addr_d = idx_q[L_RAM_SIZE-1:0];
        idx_d  = idx_q + IDX_ONE;
        if (idx_q == IDX_LAST) begin
          state_d = S_LDRAIN;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LDRAIN: begin
        // Final weight write happens this cycle; point the PE RAM at
        // element 0 ready for the first read.
        idx_d   = '0;
        addr_d  = '0;
        state_d = S_RD;
      end
      S_RD: begin
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        ain_d   = gdata;
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pe_dvalid) begin
          if (idx_q == IDX_LAST) begin
            result_d = pe_dout;
            state_d  = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            addr_d  = idx_q[L_RAM_SIZE-1:0] + ADDR_ONE;
            state_d = S_RD;
          end
        end else if (wcnt_q == WCNT_LAST) begin
          // The PE never answered: abandon the run with a zero result.
          err_d    = 1'b1;
          result_d = '0;
          state_d  = S_DONE;
        end else begin
          wcnt_d = wcnt_q + WCNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and datapath registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      wcnt_q   <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      ain_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wcnt_q   <= wcnt_d;
      err_q    <= err_d;
      result_q <= result_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      ain_q    <= ain_d;
    end
  end

  // Output decode from the registered state; the BRAM data path is
  // forwarded in the cycles where gdata carries the wanted word.
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    pe_valid = (state_q == S_ISSUE);
    pe_clr   = areset | (state_q == S_LDRAIN);
    pe_we    = we_q;
    pe_addr  = addr_q;
    err      = err_q;
    result   = result_q;
    if (we_q) begin
      pe_din = gdata;
    end else begin
      pe_din = '0;
    end
    if (state_q == S_ISSUE) begin
      pe_ain = gdata;
    end else begin
      pe_ain = ain_q;
    end
    case (state_q)
      S_LOAD:                   gaddr = idx_q;
      S_RD, S_ISSUE, S_WAIT:    gaddr = IN_BASE + idx_q;
      default:                  gaddr = '0;
    endcase
  end

endmodule

// File: tb/tb_my_pe_ctrl.sv
// Testbench for my_pe_ctrl: behavioural global BRAM and integer PE (local
// RAM with registered read, accumulator, configurable MAC latency, optional
// stalled element) driven around the DUT, checked against dot-product and
// cycle-count expectations derived from the run parameters.
module tb_my_pe_ctrl;

  localparam int SIZE = 32;
  localparam int LR   = 3;
  localparam int N    = 8;
  localparam int TO   = 64;

  logic            aclk = 1'b0;
  logic            areset, start;
  logic            busy, done, err;
  logic [SIZE-1:0] result;
  logic [LR:0]     gaddr;
  logic [SIZE-1:0] gdata;
  logic            pe_clr;
  logic [LR-1:0]   pe_addr;
  logic            pe_we;
  logic [SIZE-1:0] pe_din, pe_ain;
  logic            pe_valid, pe_dvalid;
  logic [SIZE-1:0] pe_dout;

  always #5 aclk = ~aclk;

  my_pe_ctrl #(.SIZE(SIZE), .L_RAM_SIZE(LR), .TIMEOUT(TO)) dut (
    .aclk(aclk), .areset(areset), .start(start),
    .busy(busy), .done(done), .err(err), .result(result),
    .gaddr(gaddr), .gdata(gdata),
    .pe_clr(pe_clr), .pe_addr(pe_addr), .pe_we(pe_we), .pe_din(pe_din),
    .pe_ain(pe_ain), .pe_valid(pe_valid), .pe_dvalid(pe_dvalid), .pe_dout(pe_dout)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model state
  logic [31:0] gmem [0:2*N-1];
  logic [31:0] pram [0:N-1];
  logic [31:0] rdq, acc, pend_val;
  logic [LR:0] g_prev;
  bit          pend, inject_dv;
  int          fire, cyc, lat, stall;

  // Per-run statistics
  int          t0, busy_cnt, done_cnt, done_at, vcnt, overlap, last_v, min_gap, max_gap;
  logic [31:0] res_at_done;
  logic        err_at_done;

  task automatic clear_stats();
    busy_cnt = 0; done_cnt = 0; done_at = -1; vcnt = 0; overlap = 0;
    last_v = 0; min_gap = 9999; max_gap = 0;
    res_at_done = 'x; err_at_done = 1'bx;
  endtask

  // One clock cycle: drive inputs after the falling edge, then observe the
  // DUT outputs for this cycle and advance the BRAM / PE models.
  task automatic tick(input bit st, input bit rst);
    logic [31:0] rd_new;
    int gap;
    @(negedge aclk);
    cyc++;
    start  = st;
    areset = rst;
    gdata  = gmem[g_prev];
    if (pend && fire == cyc) begin
      pe_dvalid = 1'b1;
      pe_dout   = pend_val;
      pend      = 1'b0;
    end else begin
      pe_dvalid = inject_dv;
      pe_dout   = 32'hDEAD_BEEF;
    end
    #1;
    g_prev = gaddr;
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_at     = cyc - t0;
      res_at_done = result;
      err_at_done = err;
    end
    if (pe_valid) begin
      if (pend) overlap++;
      if (vcnt > 0) begin
        gap = cyc - last_v;
        if (gap < min_gap) min_gap = gap;
        if (gap > max_gap) max_gap = gap;
      end
      last_v = cyc;
      vcnt++;
    end
    rd_new = pram[pe_addr];
    if (pe_clr) begin
      acc  = 32'd0;
      pend = 1'b0;
    end
    if (pe_valid) begin
      acc      = acc + pe_ain * rdq;
      pend_val = acc;
      pend     = 1'b1;
      fire     = (vcnt - 1 == stall) ? -1 : cyc + lat;
    end
    if (pe_we) pram[pe_addr] = pe_din;
    rdq = rd_new;
  endtask

  function automatic logic [31:0] ref_dot();
    logic [31:0] s = 32'd0;
    for (int i = 0; i < N; i++) s = s + gmem[i] * gmem[N+i];
    return s;
  endfunction

  task automatic set_vectors(input int bval, input bit rnd);
    for (int i = 0; i < N; i++) begin
      gmem[i]   = rnd ? $urandom_range(1000, 0) : bval;
      gmem[N+i] = rnd ? $urandom_range(1000, 0) : i + 1;
    end
  endtask

  task automatic run_and_check(input string tag, input int l, input int st_el, input int kick_at);
    logic [31:0] exp_res;
    int exp_done, exp_v;
    logic exp_err;
    exp_res  = (st_el < 0) ? ref_dot() : 32'd0;
    exp_err  = (st_el >= 0);
    exp_done = (st_el < 0) ? N + 2 + N*(l+2) : N + 2 + st_el*(l+2) + 2 + TO;
    exp_v    = (st_el < 0) ? N : st_el + 1;
    lat = l; stall = st_el;
    clear_stats();
    t0 = cyc + 1;
    tick(1'b1, 1'b0);
    for (int r = 1; r <= 400; r++) begin
      tick(r == kick_at, 1'b0);
      if (done_cnt > 0 && r >= done_at + 3) break;
    end
    check_eq({tag, ".done_cnt"}, done_cnt, 32'd1);
    check_eq({tag, ".done_at"}, done_at, exp_done);
    check_eq({tag, ".result"}, res_at_done, exp_res);
    check_eq({tag, ".err"}, 32'(err_at_done), 32'(exp_err));
    check_eq({tag, ".valids"}, vcnt, exp_v);
    check_eq({tag, ".overlap"}, overlap, 32'd0);
    check_eq({tag, ".busy_cycles"}, busy_cnt, exp_done);
    check_eq({tag, ".min_gap"}, min_gap, l + 2);
    check_eq({tag, ".max_gap"}, max_gap, l + 2);
  endtask

  initial begin
    areset = 1'b1; start = 1'b0; gdata = 32'd0; pe_dvalid = 1'b0; pe_dout = 32'd0;
    rdq = 32'd0; acc = 32'd0; pend_val = 32'd0; pend = 1'b0; inject_dv = 1'b0;
    fire = -1; cyc = 0; lat = 1; stall = -1; g_prev = '0; t0 = 0;
    for (int i = 0; i < N; i++) pram[i] = 32'd0;
    set_vectors(1, 1'b0);
    clear_stats();

    // Power-on reset
    tick(1'b0, 1'b1); tick(1'b0, 1'b1); tick(1'b0, 1'b1);
    check_eq("rst.pe_clr_during", 32'(pe_clr), 32'd1);
    check_eq("rst.busy_during", 32'(busy), 32'd0);
    tick(1'b0, 1'b0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.done", 32'(done), 32'd0);
    check_eq("rst.err", 32'(err), 32'd0);
    check_eq("rst.pe_we", 32'(pe_we), 32'd0);
    check_eq("rst.pe_valid", 32'(pe_valid), 32'd0);
    check_eq("rst.pe_clr", 32'(pe_clr), 32'd0);
    check_eq("rst.result", result, 32'd0);
    check_eq("rst.gaddr", 32'(gaddr), 32'd0);
    check_eq("rst.pe_addr", 32'(pe_addr), 32'd0);
    check_eq("rst.pe_din", pe_din, 32'd0);
    check_eq("rst.pe_ain", pe_ain, 32'd0);

    // Basic run: B=1, A=1..8, L=1 -> 36 at cycle 34
    set_vectors(1, 1'b0);
    run_and_check("l1", 1, -1, 0);
    // Long latency: B=2, L=5 -> 72 at cycle 66
    set_vectors(2, 1'b0);
    run_and_check("l5", 5, -1, 0);
    // Element 3 never answers -> timeout
    set_vectors(1, 1'b0);
    run_and_check("tmo", 1, 3, 0);
    tick(1'b0, 1'b0);
    check_eq("tmo.err_sticky", 32'(err), 32'd1);
    run_and_check("after_tmo", 1, -1, 0);

    // Spurious dvalid in IDLE, then start pulsed during WAIT of element 1
    inject_dv = 1'b1;
    tick(1'b0, 1'b0);
    inject_dv = 1'b0;
    tick(1'b0, 1'b0);
    check_eq("spur.busy", 32'(busy), 32'd0);
    check_eq("spur.done", 32'(done), 32'd0);
    run_and_check("kick", 1, -1, 15);

    // Reset during LOAD at cycle 4
    clear_stats();
    lat = 1; stall = -1;
    t0 = cyc + 1;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    check_eq("mid.busy_before", 32'(busy), 32'd1);
    tick(1'b0, 1'b1);
    check_eq("mid.pe_clr_c4", 32'(pe_clr), 32'd1);
    tick(1'b0, 1'b1);
    check_eq("mid.busy_c5", 32'(busy), 32'd0);
    check_eq("mid.pe_clr_c5", 32'(pe_clr), 32'd1);
    tick(1'b0, 1'b0);
    check_eq("mid.busy_after", 32'(busy), 32'd0);
    check_eq("mid.pe_we_after", 32'(pe_we), 32'd0);
    check_eq("mid.result_after", result, 32'd0);
    check_eq("mid.gaddr_after", 32'(gaddr), 32'd0);
    run_and_check("mid.fresh", 1, -1, 0);

    // Back-to-back runs with different weights
    set_vectors(3, 1'b0);
    run_and_check("b2b_1", 1, -1, 0);
    set_vectors(1, 1'b0);
    run_and_check("b2b_2", 1, -1, 0);

    // Randomised vectors and latencies
    for (int k = 0; k < 3; k++) begin
      set_vectors(0, 1'b1);
      run_and_check($sformatf("rnd%0d", k), int'($urandom_range(4, 1)), -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/my_pe_ctrl.md
# my_pe_ctrl

Sequencer for a single processing element (PE): on a start pulse it loads an N-word weight vector from global block RAM into the PE's local RAM, clears the PE accumulator, then streams the matching N-word input vector through the PE's multiply-accumulate one element at a time. It waits for each `dvalid` before issuing the next `valid`. It sits between the global vector BRAM and one PE, and returns the dot-product result with a one-cycle done pulse.

## Interface
Parameters:
- `SIZE`, 32, data word width (matches PE `SIZE`)
- `L_RAM_SIZE`, 3, log2 of vector length; N = 2**L_RAM_SIZE
- `TIMEOUT`, 64, max cycles to wait for `pe_dvalid` per element

Ports:
- `aclk` in 1: clock, all logic on rising edge
- `areset` in 1: reset is synchronous and active-high
- `start` in 1: one-cycle request; sampled only in IDLE
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse when the run ends
- `err` out 1: sticky timeout flag; cleared on the next accepted `start`
- `result` out SIZE: final PE output; held until the next run's DONE
- `gaddr` out L_RAM_SIZE+1: global BRAM read address; weights at 0..N-1, inputs at N..2N-1
- `gdata` in SIZE: global BRAM read data, valid 1 cycle after `gaddr`
- `pe_clr` out 1: accumulator clear to PE (PE `aresetn` = ~`pe_clr`)
- `pe_addr` out L_RAM_SIZE: PE local RAM address
- `pe_we` out 1: PE local RAM write enable
- `pe_din` out SIZE: PE local RAM write data
- `pe_ain` out SIZE: PE multiplicand A
- `pe_valid` out 1: PE MAC operand valid
- `pe_dvalid` in 1: PE MAC result valid
- `pe_dout` in SIZE: PE MAC result

## Operation
- States: IDLE, LOAD, LDRAIN, RD, ISSUE, WAIT, DONE. `idx` is an L_RAM_SIZE+1-bit counter. `wcnt` is a timeout counter.
- IDLE: `start`=1 moves to LOAD, sets `idx`=0, and clears `err`. `pe_dvalid` is ignored here.
- LOAD: drives `gaddr`=`idx` and increments `idx`. After issuing `idx`=N-1 it moves to LDRAIN.
- Weight write pipeline, every LOAD cycle after the first plus LDRAIN:
  - `pe_we`=1
  - `pe_addr`=previous `idx` (registered)
  - `pe_din`=`gdata`
- LDRAIN: performs the final write (`pe_addr`=N-1), asserts `pe_clr`=1, sets `idx`=0, then moves to RD.
- RD: drives `gaddr`=N+`idx`, `pe_addr`=`idx`, `pe_we`=0. Moves to ISSUE.
- ISSUE: `pe_valid`=1 and `pe_ain`=`gdata` (registered into a hold register). Moves to WAIT and sets `wcnt`=0.
- WAIT: holds `pe_addr` and `pe_ain`; `pe_valid`=0. Transitions on `pe_dvalid`:
  - `pe_dvalid`=1 with `idx`<N-1: increment `idx`, go to RD.
  - `pe_dvalid`=1 with `idx`=N-1: `result`<=`pe_dout`, go to DONE.
  - `wcnt`=TIMEOUT-1 without `pe_dvalid`: `err`<=1, `result`<=0, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored and is not queued.
- `pe_dvalid` outside WAIT is ignored.
- Exactly one `pe_valid` is outstanding at any time, because the PE accumulator feeds back its previous `dout`.
- Outputs default to 0 when not driven by the current state: `pe_we`, `pe_valid`, `pe_clr`, `done`.
- Reset, including mid-run: next state IDLE. While `areset`=1, `pe_clr`=1, which clears the PE accumulator.
- Reset values after reset: `busy`, `done`, `err`, `pe_we`, `pe_valid` all 0; `result`=0, `gaddr`=0, `pe_addr`=0, `pe_din`=0, `pe_ain`=0. A half-loaded PE RAM is left as is and is reloaded on the next run.

## Timing
- `start` is sampled at cycle 0.
- LOAD runs cycles 1..N. Weight writes occur at cycles 2..N+1. LDRAIN is cycle N+1.
- With MAC latency L (`pe_dvalid` L≥1 cycles after `pe_valid`), each element takes L+2 cycles. Element k's RD is at cycle N+2+k(L+2).
- `done` is at cycle N+2+N(L+2). With N=8, L=1, that is cycle 34.
- `result` is valid from the `done` cycle onward.
- `busy` is high from cycle 1 through the `done` cycle.
- `pe_addr` is stable from RD through WAIT, so the PE's registered RAM read presents B[idx] by the ISSUE cycle.

## Test plan
- Bench uses an integer behavioural PE with L=1, N=8. Load B=1×8, A=1..8, pulse `start` → `done` at cycle 34, `result`=36, `err`=0, 8 `pe_valid` pulses, no two outstanding.
- L=5, B=2×8, A=1..8 → `result`=72, `done` at cycle 66; each `pe_valid` is followed by 6 cycles with `pe_valid`=0.
- PE never asserts `dvalid` on element 3 → after 64 WAIT cycles `err`=1, `result`=0, one `done` pulse. The next `start` clears `err`, and a good run returns 36.
- `start` pulsed during WAIT, plus a spurious `pe_dvalid` in IDLE → no restart, no state change, single `done`.
- Assert `areset` during LOAD at cycle 4 → IDLE next cycle, `busy`=0 and `pe_clr`=1 during reset. A fresh run returns 36.
- Two back-to-back runs with different B → second `result` excludes the first run's sum, which confirms `pe_clr` clears the accumulator.
